// File: rtl/param_bcd_counter.sv
// Parameterised up/down BCD counter with load, wrap or saturate at the bounds,
// a registered terminal-count pulse and a combinational seven-segment decode.
module param_bcd_counter #(
  parameter int unsigned DIGITS         = 3,
  parameter int unsigned WRAP           = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  up_dn,
  output logic [4*DIGITS-1:0]   count,
  output logic [7*DIGITS-1:0]   ssg,
  output logic                  tc
);

  localparam int unsigned CW  = 4 * DIGITS;
  localparam int unsigned SW  = 7 * DIGITS;
  localparam logic        INV = (SEG_ACTIVE_LOW != 0);
  localparam logic        SAT = (WRAP == 0);

  logic [CW-1:0] count_q, count_d;
  logic          tc_q, tc_d;
  logic [CW-1:0] step_val, load_clamped;
  logic [3:0]    digit, ld_digit;
  logic          at_max, at_zero, at_bound, carry;
  logic [SW-1:0] ssg_raw;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  // Per-digit ripple: carry (up) or borrow (down) passes through digits at the limit.
  always_comb begin
    load_clamped = '0;
    step_val     = '0;
    digit        = '0;
    ld_digit     = '0;
    at_max       = 1'b1;
    at_zero      = 1'b1;
    carry        = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      digit    = count_q[4*i +: 4];
      ld_digit = load_val[4*i +: 4];
      load_clamped[4*i +: 4] = (ld_digit > 4'd9) ? 4'd9 : ld_digit;
      at_max  = at_max  & (digit == 4'd9);
      at_zero = at_zero & (digit == 4'd0);
      if (!carry) begin
        step_val[4*i +: 4] = digit;
      end else if (up_dn) begin
        if (digit == 4'd9) begin
          step_val[4*i +: 4] = 4'd0;
        end else begin
          step_val[4*i +: 4] = digit + 4'd1;
          carry = 1'b0;
        end
      end else begin
        if (digit == 4'd0) begin
          step_val[4*i +: 4] = 4'd9;
        end else begin
          step_val[4*i +: 4] = digit - 4'd1;
          carry = 1'b0;
        end
      end
    end
    at_bound = up_dn ? at_max : at_zero;
  end

  // Next state: load beats enable; a full ripple at a bound is the wrap value.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_clamped;
    end else if (enable) begin
      tc_d = at_bound;
      if (!(at_bound && SAT)) begin
        count_d = step_val;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    ssg_raw = '0;
    for (int i = 0; i < DIGITS; i++) begin
      ssg_raw[7*i +: 7] = seg7(count_q[4*i +: 4]);
    end
  end

  assign ssg   = ssg_raw ^ {SW{INV}};
  assign count = count_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_param_bcd_counter.sv
// Randomised and directed bench for param_bcd_counter against an integer-valued
// reference model; three instances cover wrap/saturate, inverted segments and one digit.
module tb_param_bcd_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, load, up_dn;
  logic [11:0] load_val;

  logic [11:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;
  logic [20:0] ssg_a, ssg_b;
  logic [6:0]  ssg_c;
  logic        tc_a, tc_b, tc_c;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: decimal value and expected tc for each instance.
  int va, vb, vc;
  bit ta, tb_m, tcm;

  param_bcd_counter #(.DIGITS(3), .WRAP(1), .SEG_ACTIVE_LOW(0)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .load_val(load_val),
    .up_dn(up_dn), .count(cnt_a), .ssg(ssg_a), .tc(tc_a));

  param_bcd_counter #(.DIGITS(3), .WRAP(0), .SEG_ACTIVE_LOW(1)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .load_val(load_val),
    .up_dn(up_dn), .count(cnt_b), .ssg(ssg_b), .tc(tc_b));

  param_bcd_counter #(.DIGITS(1), .WRAP(1), .SEG_ACTIVE_LOW(0)) dut_c (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .load_val(load_val[3:0]),
    .up_dn(up_dn), .count(cnt_c), .ssg(ssg_c), .tc(tc_c));

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
            7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
    return tbl[d];
  endfunction

  function automatic logic [63:0] to_bcd(input int v, input int d);
    logic [63:0] r = '0;
    int p = 1;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_ssg(input int v, input int d, input bit inv);
    logic [63:0] r = '0;
    int p = 1;
    for (int i = 0; i < d; i++) begin
      r[7*i +: 7] = seg_ref((v / p) % 10) ^ {7{inv}};
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int clamp_int(input logic [11:0] lv, input int d);
    int v = 0;
    int p = 1;
    int dig;
    for (int i = 0; i < d; i++) begin
      dig = int'(lv[4*i +: 4]);
      if (dig > 9) dig = 9;
      v = v + dig * p;
      p = p * 10;
    end
    return v;
  endfunction

  task automatic mstep(input int v, input int maxv, input bit wrap, input logic en,
                       input logic ld, input logic ud, input int ldv,
                       output int nv, output bit nt);
    nt = 1'b0;
    nv = v;
    if (ld) nv = ldv;
    else if (en) begin
      if (ud) begin
        if (v == maxv) begin nt = 1'b1; nv = wrap ? 0 : maxv; end
        else nv = v + 1;
      end else begin
        if (v == 0) begin nt = 1'b1; nv = wrap ? maxv : 0; end
        else nv = v - 1;
      end
    end
  endtask

  task automatic check_all();
    chk("cnt_a", 64'(cnt_a), to_bcd(va, 3));
    chk("tc_a",  64'(tc_a),  64'(ta));
    chk("ssg_a", 64'(ssg_a), exp_ssg(va, 3, 1'b0));
    chk("cnt_b", 64'(cnt_b), to_bcd(vb, 3));
    chk("tc_b",  64'(tc_b),  64'(tb_m));
    chk("ssg_b", 64'(ssg_b), exp_ssg(vb, 3, 1'b1));
    chk("cnt_c", 64'(cnt_c), to_bcd(vc, 1));
    chk("tc_c",  64'(tc_c),  64'(tcm));
    chk("ssg_c", 64'(ssg_c), exp_ssg(vc, 1, 1'b0));
  endtask

  task automatic cyc(input logic en, input logic ld, input logic ud, input logic [11:0] lv);
    @(negedge clk);
    enable = en; load = ld; up_dn = ud; load_val = lv;
    @(posedge clk);
    mstep(va, 999, 1'b1, en, ld, ud, clamp_int(lv, 3), va, ta);
    mstep(vb, 999, 1'b0, en, ld, ud, clamp_int(lv, 3), vb, tb_m);
    mstep(vc, 9,   1'b1, en, ld, ud, clamp_int(lv, 1), vc, tcm);
    #1 check_all();
  endtask

  initial begin
    int tcn;
    logic [11:0] picks [5];
    picks = '{12'h999, 12'h000, 12'h099, 12'h990, 12'h909};

    reset = 1'b0; enable = 1'b0; load = 1'b0; up_dn = 1'b1; load_val = '0;
    va = 0; vb = 0; vc = 0; ta = 0; tb_m = 0; tcm = 0;
    #3 check_all();
    chk("rst_ssg_a", 64'(ssg_a), 64'({3{7'b0111111}}));
    @(negedge clk) reset = 1'b1;

    // Full up sweep with wrap: exactly one tc pulse, after 999->000.
    tcn = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 12'h000);
      if (tc_a) tcn++;
    end
    chk("sweep_end", 64'(cnt_a), 64'h000);
    chk("sweep_tcn", 64'(tcn), 64'd1);

    // Down wrap from zero.
    cyc(1'b0, 1'b1, 1'b0, 12'h000);
    cyc(1'b1, 1'b0, 1'b0, 12'h000);
    chk("dn_wrap", 64'(cnt_a), 64'h999);
    chk("dn_wrap_tc", 64'(tc_a), 64'd1);
    cyc(1'b1, 1'b0, 1'b0, 12'h000);
    chk("dn_998", 64'(cnt_a), 64'h998);
    chk("dn_998_tc", 64'(tc_a), 64'd0);

    // Saturation at MAX with repeated tc.
    cyc(1'b0, 1'b1, 1'b1, 12'h999);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 12'h000);
      chk("sat_cnt", 64'(cnt_b), 64'h999);
      chk("sat_tc", 64'(tc_b), 64'd1);
    end
    cyc(1'b1, 1'b0, 1'b0, 12'h000);
    chk("sat_dn", 64'(cnt_b), 64'h998);
    chk("sat_dn_tc", 64'(tc_b), 64'd0);

    // Clamp of a non-BCD digit, and load beating enable.
    cyc(1'b0, 1'b1, 1'b1, 12'h1F5);
    chk("clamp", 64'(cnt_a), 64'h195);
    cyc(1'b1, 1'b1, 1'b1, 12'h123);
    chk("ld_wins", 64'(cnt_a), 64'h123);
    chk("ld_tc", 64'(tc_a), 64'd0);

    // Carry and borrow ripple.
    cyc(1'b0, 1'b1, 1'b1, 12'h099);
    cyc(1'b1, 1'b0, 1'b1, 12'h000);
    chk("ripple_up", 64'(cnt_a), 64'h100);
    chk("ripple_ssg", 64'(ssg_a), 64'({7'b0000110, 7'b0111111, 7'b0111111}));
    cyc(1'b0, 1'b1, 1'b1, 12'h100);
    cyc(1'b1, 1'b0, 1'b0, 12'h000);
    chk("ripple_dn", 64'(cnt_a), 64'h099);

    // Asynchronous reset between edges while tc is high.
    cyc(1'b0, 1'b1, 1'b1, 12'h999);
    cyc(1'b1, 1'b0, 1'b1, 12'h000);
    chk("pre_rst_tc", 64'(tc_a), 64'd1);
    #2 reset = 1'b0;
    #1;
    va = 0; vb = 0; vc = 0; ta = 0; tb_m = 0; tcm = 0;
    check_all();
    chk("rst_ssg_b", 64'(ssg_b), 64'({3{7'b1000000}}));
    enable = 1'b0; load = 1'b0;
    @(negedge clk) reset = 1'b1;

    // Randomised traffic biased toward the bounds.
    for (int i = 0; i < 2000; i++) begin
      logic [11:0] lv;
      lv = ($urandom_range(0, 1) == 0) ? 12'($urandom) : picks[$urandom_range(0, 4)];
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
          1'($urandom_range(0, 1)), lv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
